// File: rtl/mem_pkg.sv
// Shared encodings for the dual-port memory: port-A read-during-write modes
// and the clear controller state type.
package mem_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } read_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/memory_clear_ctrl.sv
// Post-reset zero-fill sequencer: sweeps every address once, then reports the
// array as ready for port accesses.
module memory_clear_ctrl
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    output logic                     clr_we,
    output logic [ADDRESS_WIDTH-1:0] clr_addr
);

    clr_state_e               r_state;
    clr_state_e               w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Without zero-fill, CLEAR only serves as the one-cycle exit from reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR: begin
                if (CLEAR_ON_RESET == 0 || r_cnt == '1) begin
                    w_next_state = IDLE;
                end
            end
            IDLE:    w_next_state = IDLE;
            default: w_next_state = CLEAR;
        endcase
    end

    assign ready    = (r_state == IDLE) && !rst;
    assign clr_we   = (r_state == CLEAR) && (CLEAR_ON_RESET != 0) && !rst;
    assign clr_addr = r_cnt;

endmodule

// File: rtl/memory_dual_port.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only,
// optional output register stage and post-reset zero-fill.
module memory_dual_port
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int BYPASS         = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     a_en,
    input  logic                     a_we,
    input  logic [DATA_WIDTH/8-1:0]  a_be,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_din,
    output logic [DATA_WIDTH-1:0]    a_dout,
    output logic                     a_valid,
    input  logic                     b_en,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0]    b_dout,
    output logic                     b_valid
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    logic                     w_ready;
    logic                     w_clr_we;
    logic [ADDRESS_WIDTH-1:0] w_clr_addr;

    logic                     w_a_acc;
    logic                     w_a_wr;
    logic                     w_a_upd;
    logic                     w_b_acc;
    logic                     w_collide;
    logic [DATA_WIDTH-1:0]    w_a_old;
    logic [DATA_WIDTH-1:0]    w_a_new;
    logic [DATA_WIDTH-1:0]    w_a_rd;
    logic [DATA_WIDTH-1:0]    w_b_rd;

    logic [DATA_WIDTH-1:0]    r_a_dout_p0;
    logic                     r_a_vld_p0;
    logic [DATA_WIDTH-1:0]    r_b_dout_p0;
    logic                     r_b_vld_p0;

    memory_clear_ctrl #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .ready    (w_ready),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign ready = w_ready;

    assign w_a_acc = a_en && w_ready;
    assign w_a_wr  = w_a_acc && a_we;
    assign w_b_acc = b_en && w_ready;

    assign w_a_old = r_mem[a_addr];
    assign w_a_new = merge_bytes(w_a_old, a_din, a_be);

    // No-change mode keeps the previous port-A result and suppresses the pulse.
    assign w_a_upd = w_a_acc && !(a_we && READ_MODE == int'(NO_CHANGE));
    assign w_a_rd  = (a_we && READ_MODE == int'(WRITE_FIRST)) ? w_a_new : w_a_old;

    assign w_collide = (BYPASS != 0) && w_a_wr && (a_addr == b_addr);
    assign w_b_rd    = w_collide ? w_a_new : r_mem[b_addr];

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_a_wr) begin
            r_mem[a_addr] <= w_a_new;
        end
    end

    // Stage p0: array read result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dout_p0 <= '0;
            r_a_vld_p0  <= 1'b0;
            r_b_dout_p0 <= '0;
            r_b_vld_p0  <= 1'b0;
        end else begin
            r_a_vld_p0 <= w_a_upd;
            r_b_vld_p0 <= w_b_acc;
            if (w_a_upd) begin
                r_a_dout_p0 <= w_a_rd;
            end
            if (w_b_acc) begin
                r_b_dout_p0 <= w_b_rd;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_a_dout_p1;
            logic                  r_a_vld_p1;
            logic [DATA_WIDTH-1:0] r_b_dout_p1;
            logic                  r_b_vld_p1;

            // Stage p1: optional output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_dout_p1 <= '0;
                    r_a_vld_p1  <= 1'b0;
                    r_b_dout_p1 <= '0;
                    r_b_vld_p1  <= 1'b0;
                end else begin
                    r_a_vld_p1 <= r_a_vld_p0;
                    r_b_vld_p1 <= r_b_vld_p0;
                    if (r_a_vld_p0) begin
                        r_a_dout_p1 <= r_a_dout_p0;
                    end
                    if (r_b_vld_p0) begin
                        r_b_dout_p1 <= r_b_dout_p0;
                    end
                end
            end

            assign a_dout  = r_a_dout_p1;
            assign a_valid = r_a_vld_p1;
            assign b_dout  = r_b_dout_p1;
            assign b_valid = r_b_vld_p1;
        end else begin : g_no_out_reg
            assign a_dout  = r_a_dout_p0;
            assign a_valid = r_a_vld_p0;
            assign b_dout  = r_b_dout_p0;
            assign b_valid = r_b_vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_memory_dual_port.sv
// Scoreboard bench for memory_dual_port: three configurations share one
// stimulus stream; a negedge monitor matches every valid pulse to its queue entry.
module tb_memory_dual_port;

    typedef struct {
        int          s;
        int          cyc;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_en;
    logic        a_we;
    logic [3:0]  a_be;
    logic [3:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [3:0]  b_addr;

    logic        ready0, ready1, ready2;
    logic [31:0] a_dout0, a_dout1, a_dout2;
    logic [31:0] b_dout0, b_dout1, b_dout2;
    logic        a_valid0, a_valid1, a_valid2;
    logic        b_valid0, b_valid1, b_valid2;

    logic        vld [6];
    logic [31:0] dat [6];
    string       names [6];

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    // write-first, bypass, latency 1
    memory_dual_port #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_MODE(0),
        .OUT_REG(0), .CLEAR_ON_RESET(1), .BYPASS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout0), .a_valid(a_valid0),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0)
    );

    // read-first, no bypass, latency 1
    memory_dual_port #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_MODE(1),
        .OUT_REG(0), .CLEAR_ON_RESET(1), .BYPASS(0)
    ) dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_valid(a_valid1),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1)
    );

    // no-change, bypass, latency 2
    memory_dual_port #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_MODE(2),
        .OUT_REG(1), .CLEAR_ON_RESET(1), .BYPASS(1)
    ) dut2 (
        .clk(clk), .rst(rst), .ready(ready2),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout2), .a_valid(a_valid2),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout2), .b_valid(b_valid2)
    );

    assign vld[0] = a_valid0;  assign dat[0] = a_dout0;
    assign vld[1] = b_valid0;  assign dat[1] = b_dout0;
    assign vld[2] = a_valid1;  assign dat[2] = a_dout1;
    assign vld[3] = b_valid1;  assign dat[3] = b_dout1;
    assign vld[4] = a_valid2;  assign dat[4] = a_dout2;
    assign vld[5] = b_valid2;  assign dat[5] = b_dout2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int lat(input int s);
        return (s >= 4) ? 2 : 1;
    endfunction

    task automatic push(input int s, input logic [31:0] d);
        q.push_back('{s, cyc + lat(s), d});
    endtask

    task automatic push_a(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic has2);
        push(0, d0);
        push(2, d1);
        if (has2) push(4, d2);
    endtask

    task automatic push_b(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        push(1, d0);
        push(3, d1);
        push(5, d2);
    endtask

    task automatic step(input logic ae, input logic awe, input logic [3:0] abe,
                        input logic [3:0] aad, input logic [31:0] adin,
                        input logic ben, input logic [3:0] bad);
        a_en   = ae;
        a_we   = awe;
        a_be   = abe;
        a_addr = aad;
        a_din  = adin;
        b_en   = ben;
        b_addr = bad;
        @(posedge clk);
        #1;
        a_en = 1'b0;
        a_we = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready0"}, {31'b0, ready0}, 32'd0);
        check({tag, " ready2"}, {31'b0, ready2}, 32'd0);
        check({tag, " a_valid0"}, {31'b0, a_valid0}, 32'd0);
        check({tag, " b_valid1"}, {31'b0, b_valid1}, 32'd0);
        check({tag, " b_valid2"}, {31'b0, b_valid2}, 32'd0);
        check({tag, " a_dout0"}, a_dout0, 32'd0);
        check({tag, " a_dout1"}, a_dout1, 32'd0);
        check({tag, " a_dout2"}, a_dout2, 32'd0);
        check({tag, " b_dout0"}, b_dout0, 32'd0);
        check({tag, " b_dout2"}, b_dout2, 32'd0);
    endtask

    // Monitor: every valid pulse must match the oldest pending entry of its stream.
    always @(negedge clk) begin
        for (int s = 0; s < 6; s++) begin
            if (vld[s] === 1'b1) begin
                int idx;
                idx = -1;
                for (int k = 0; k < q.size(); k++) begin
                    if (idx < 0 && q[k].s == s) idx = k;
                end
                if (idx < 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s unexpected valid at cycle %0d, data %h, required no pulse",
                             names[s], cyc, dat[s]);
                end else begin
                    check({names[s], " latency"}, cyc, q[idx].cyc);
                    check({names[s], " data"}, dat[s], q[idx].d);
                    q.delete(idx);
                end
            end
        end
    end

    initial begin
        names[0] = "dut0.A"; names[1] = "dut0.B";
        names[2] = "dut1.A"; names[3] = "dut1.B";
        names[4] = "dut2.A"; names[5] = "dut2.B";
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        a_en  = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_din = 32'h0;
        b_en  = 1'b0; b_addr = 4'h0;

        idle(3);
        check_reset_outputs("reset");

        // Release, then reset again at clear cycle 7
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            idle(1);
            check("clear ready0", {31'b0, ready0}, 32'd0);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;

        // Clear restarts from 0: ready exactly 16 edges after release
        for (int i = 1; i <= 16; i++) begin
            if (i == 10) step(1'b1, 1'b1, 4'hF, 4'h0, 32'hFFFF_FFFF, 1'b1, 4'h0);
            else         idle(1);
            check("restart ready0", {31'b0, ready0}, {31'b0, (i == 16)});
            check("restart ready1", {31'b0, ready1}, {31'b0, (i == 16)});
            check("restart ready2", {31'b0, ready2}, {31'b0, (i == 16)});
        end

        // Back-to-back reads of the whole cleared array on both ports
        for (int i = 0; i < 16; i++) begin
            push_b(32'h0, 32'h0, 32'h0);
            push_a(32'h0, 32'h0, 32'h0, 1'b1);
            step(1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0, 1'b1, 4'(i));
        end

        // Full write then partial byte write to address 3
        push_a(32'h1122_3344, 32'h0000_0000, 32'h0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'h3, 32'h1122_3344, 1'b0, 4'h0);
        push_a(32'h1122_3344, 32'h1122_3344, 32'h1122_3344, 1'b1);
        step(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, 1'b0, 4'h0);
        push_a(32'h11BB_33DD, 32'h1122_3344, 32'h0, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 4'h3, 32'hAABB_CCDD, 1'b0, 4'h0);
        idle(1);
        check("dut2 no-change a_dout", a_dout2, 32'h1122_3344);
        push_a(32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 1'b1);
        push_b(32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD);
        step(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, 1'b1, 4'h3);

        // Same-address A-write / B-read collision on address 5
        push_a(32'h5566_7788, 32'h0000_0000, 32'h0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'h5, 32'h5566_7788, 1'b0, 4'h0);
        push_a(32'hDEAD_BEEF, 32'h5566_7788, 32'h0, 1'b0);
        push_b(32'hDEAD_BEEF, 32'h5566_7788, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 4'hF, 4'h5, 32'hDEAD_BEEF, 1'b1, 4'h5);

        // Zero byte-enable write leaves address 3 intact
        push_a(32'h11BB_33DD, 32'h11BB_33DD, 32'h0, 1'b0);
        push_b(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 4'h0, 4'h3, 32'h0000_0000, 1'b1, 4'h5);
        idle(3);
        check("hold b_dout0", b_dout0, 32'hDEAD_BEEF);
        check("hold b_dout1", b_dout1, 32'hDEAD_BEEF);
        check("hold b_dout2", b_dout2, 32'hDEAD_BEEF);
        check("hold a_dout0", a_dout0, 32'h11BB_33DD);
        check("hold a_dout1", a_dout1, 32'h11BB_33DD);
        push_a(32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 1'b1);
        push_b(32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, 1'b1, 4'h4);
        idle(3);

        // Reset while a latency-2 read is in flight: that pulse must vanish
        push(1, 32'h11BB_33DD);
        push(3, 32'h11BB_33DD);
        step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3);
        rst = 1'b1;
        idle(4);
        check_reset_outputs("reset2");

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries pending, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
